// File: rtl/first_stage_fetch_responder.sv
// Memory-side responder for the first-stage quadrant address generator: queues pixel
// address strobes, reads the input RAM under output-FIFO credit, and fetches B elements.
module first_stage_fetch_responder #(
  parameter int ADDR_W    = 12,
  parameter int B_ADDR_W  = 9,
  parameter int DATA_W    = 8,
  parameter int B_DATA_W  = 16,
  parameter int REQ_DEPTH = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                clock,
  input  logic                clear_n,
  input  logic                en,
  input  logic [ADDR_W-1:0]   input_address,
  input  logic                input_address_ready,
  input  logic [B_ADDR_W-1:0] b_element_address,
  input  logic                b_element_requested,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [B_ADDR_W-1:0] bmem_addr,
  output logic                bmem_rd,
  input  logic [B_DATA_W-1:0] bmem_data,
  output logic [DATA_W-1:0]   pixel_data,
  output logic                pixel_valid,
  input  logic                pixel_ready,
  output logic [B_DATA_W-1:0] b_element_data,
  output logic                b_element_valid,
  output logic                busy,
  output logic                overflow
);
  localparam int RP_W = $clog2(REQ_DEPTH);
  localparam int OP_W = $clog2(OUT_DEPTH);
  localparam int CR_W = OP_W + 2;

  logic [ADDR_W-1:0]   req_mem_q [REQ_DEPTH];
  logic [ADDR_W-1:0]   req_mem_d [REQ_DEPTH];
  logic [RP_W-1:0]     req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [RP_W:0]       req_cnt_q, req_cnt_d;
  logic [DATA_W-1:0]   out_mem_q [OUT_DEPTH];
  logic [DATA_W-1:0]   out_mem_d [OUT_DEPTH];
  logic [OP_W-1:0]     out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OP_W:0]       out_cnt_q, out_cnt_d;
  logic                mem_rd_q, mem_rd_d, rd_pend_q, rd_pend_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                bmem_rd_q, bmem_rd_d, b_vld_q, b_vld_d;
  logic [B_ADDR_W-1:0] bmem_addr_q, bmem_addr_d;
  logic [B_DATA_W-1:0] b_hold_q, b_hold_d;

  logic              req_empty, req_full, req_pop, req_push, issue, credit_ok;
  logic              out_empty, out_pop;
  logic [ADDR_W-1:0] req_head;
  logic [CR_W-1:0]   used;

  // An empty request FIFO is bypassed so a strobe can issue in its own cycle.
  always_comb begin
    req_empty = (req_cnt_q == '0);
    req_full  = (req_cnt_q == (RP_W+1)'(REQ_DEPTH));
    req_head  = req_empty ? input_address : req_mem_q[req_rd_q];
    // Credit covers the buffered words plus the read on the bus and the one landing now.
    used      = CR_W'(out_cnt_q) + CR_W'(mem_rd_q) + CR_W'(rd_pend_q);
    credit_ok = (used < CR_W'(OUT_DEPTH));
    issue     = en && (!req_empty || input_address_ready) && credit_ok;
    req_pop   = issue && !req_empty;
    req_push  = input_address_ready && (!req_empty || !issue) && (!req_full || req_pop);
    out_empty = (out_cnt_q == '0);
    out_pop   = !out_empty && pixel_ready;
  end

  always_comb begin
    req_mem_d = req_mem_q;
    req_wr_d  = req_wr_q;
    req_rd_d  = req_rd_q;
    if (req_push) begin
      req_mem_d[req_wr_q] = input_address;
      req_wr_d            = req_wr_q + 1'b1;
    end
    if (req_pop) req_rd_d = req_rd_q + 1'b1;
    req_cnt_d  = req_cnt_q + (RP_W+1)'(req_push) - (RP_W+1)'(req_pop);
    ovf_d      = ovf_q | (input_address_ready & req_full & ~req_pop);
    mem_rd_d   = issue;
    mem_addr_d = issue ? req_head : mem_addr_q;
    rd_pend_d  = mem_rd_q;
  end

  always_comb begin
    out_mem_d = out_mem_q;
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    if (rd_pend_q) begin
      out_mem_d[out_wr_q] = mem_data;
      out_wr_d            = out_wr_q + 1'b1;
    end
    if (out_pop) out_rd_d = out_rd_q + 1'b1;
    out_cnt_d = out_cnt_q + (OP_W+1)'(rd_pend_q) - (OP_W+1)'(out_pop);
  end

  // B path: two-stage pipeline, the RAM word is presented directly on the valid cycle.
  always_comb begin
    bmem_rd_d   = b_element_requested;
    bmem_addr_d = b_element_requested ? b_element_address : bmem_addr_q;
    b_vld_d     = bmem_rd_q;
    b_hold_d    = b_vld_q ? bmem_data : b_hold_q;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < REQ_DEPTH; i++) req_mem_q[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
      req_wr_q    <= '0;
      req_rd_q    <= '0;
      req_cnt_q   <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_cnt_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      rd_pend_q   <= 1'b0;
      ovf_q       <= 1'b0;
      bmem_rd_q   <= 1'b0;
      bmem_addr_q <= '0;
      b_vld_q     <= 1'b0;
      b_hold_q    <= '0;
    end else begin
      req_mem_q   <= req_mem_d;
      out_mem_q   <= out_mem_d;
      req_wr_q    <= req_wr_d;
      req_rd_q    <= req_rd_d;
      req_cnt_q   <= req_cnt_d;
      out_wr_q    <= out_wr_d;
      out_rd_q    <= out_rd_d;
      out_cnt_q   <= out_cnt_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      rd_pend_q   <= rd_pend_d;
      ovf_q       <= ovf_d;
      bmem_rd_q   <= bmem_rd_d;
      bmem_addr_q <= bmem_addr_d;
      b_vld_q     <= b_vld_d;
      b_hold_q    <= b_hold_d;
    end
  end

  assign mem_rd          = mem_rd_q;
  assign mem_addr        = mem_addr_q;
  assign bmem_rd         = bmem_rd_q;
  assign bmem_addr       = bmem_addr_q;
  assign pixel_valid     = !out_empty;
  assign pixel_data      = out_empty ? '0 : out_mem_q[out_rd_q];
  assign b_element_valid = b_vld_q;
  assign b_element_data  = b_vld_q ? bmem_data : b_hold_q;
  assign overflow        = ovf_q;
  assign busy            = !req_empty || mem_rd_q || rd_pend_q || !out_empty;

endmodule

// File: tb/tb_first_stage_fetch_responder.sv
// Scoreboard bench: stimulus pushes expected RAM words, negedge monitors pop and compare.
module tb_first_stage_fetch_responder;
  localparam int ADDR_W = 12, B_ADDR_W = 9, DATA_W = 8, B_DATA_W = 16;
  localparam int REQ_DEPTH = 4, OUT_DEPTH = 4;

  logic                clock = 1'b0;
  logic                clear_n, en, input_address_ready, b_element_requested, pixel_ready;
  logic [ADDR_W-1:0]   input_address, mem_addr;
  logic [B_ADDR_W-1:0] b_element_address, bmem_addr;
  logic                mem_rd, bmem_rd, pixel_valid, b_element_valid, busy, overflow;
  logic [DATA_W-1:0]   mem_data = '0;
  logic [DATA_W-1:0]   pixel_data;
  logic [B_DATA_W-1:0] bmem_data = '0;
  logic [B_DATA_W-1:0] b_element_data;

  first_stage_fetch_responder #(
    .ADDR_W(ADDR_W), .B_ADDR_W(B_ADDR_W), .DATA_W(DATA_W), .B_DATA_W(B_DATA_W),
    .REQ_DEPTH(REQ_DEPTH), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clock(clock), .clear_n(clear_n), .en(en),
    .input_address(input_address), .input_address_ready(input_address_ready),
    .b_element_address(b_element_address), .b_element_requested(b_element_requested),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .bmem_addr(bmem_addr), .bmem_rd(bmem_rd), .bmem_data(bmem_data),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .b_element_data(b_element_data), .b_element_valid(b_element_valid),
    .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0]   ram  [1<<ADDR_W];
  logic [B_DATA_W-1:0] bram [1<<B_ADDR_W];
  always @(posedge clock) begin
    if (mem_rd)  mem_data  <= ram[mem_addr];
    if (bmem_rd) bmem_data <= bram[bmem_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [B_DATA_W-1:0] d; int c; } bexp_t;
  logic [DATA_W-1:0] sb[$];
  bexp_t             bq[$];
  bexp_t             be;
  int n_pass = 0, n_chk = 0, rd_cnt = 0, delivered = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clock) begin
    if (mem_rd) rd_cnt++;
    if (pixel_valid) begin
      if (sb.size() == 0) chk("pixel_spurious", pixel_valid, 1'b0);
      else if (pixel_ready) begin
        chk("pixel_data", pixel_data, sb.pop_front());
        delivered++;
      end
    end
    if (b_element_valid) begin
      if (bq.size() == 0) chk("b_spurious", b_element_valid, 1'b0);
      else begin
        be = bq.pop_front();
        chk("b_data", b_element_data, be.d);
        chk("b_cycle", cyc, be.c);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain(input string nm, input int lim);
    int k = 0;
    while ((sb.size() != 0 || bq.size() != 0) && k < lim) begin
      step();
      k++;
    end
    chk(nm, 32'(sb.size() + bq.size()), 0);
  endtask

  task automatic push_b(input logic [B_ADDR_W-1:0] a);
    b_element_address   = a;
    b_element_requested = 1'b1;
    bq.push_back('{d: bram[a], c: cyc + 2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at time limit, expected $finish earlier");
    $fatal(1);
  end

  logic [B_ADDR_W-1:0] ba [3];
  logic [ADDR_W-1:0]   ra;
  int r0, d0, n_rand;

  initial begin
    clear_n = 1'b0; en = 1'b0; pixel_ready = 1'b0;
    input_address = '0; input_address_ready = 1'b0;
    b_element_address = '0; b_element_requested = 1'b0;
    for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = DATA_W'($urandom);
    for (int i = 0; i < (1<<B_ADDR_W); i++) bram[i] = B_DATA_W'($urandom);
    ram[12'h2A5] = 8'h5C;
    for (int i = 0; i < 6; i++) ram[i] = 8'(8'h10 + i);
    for (int i = 0; i < 5; i++) ram[12'h100 + i] = 8'(8'hA0 + i);
    ba[0] = 9'h003; ba[1] = 9'h1FF; ba[2] = 9'h000;

    step(3);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_b_valid", b_element_valid, 0);
    clear_n = 1'b1;
    step();

    // single strobe latency
    en = 1'b1; pixel_ready = 1'b1;
    input_address = 12'h2A5; input_address_ready = 1'b1;
    sb.push_back(ram[12'h2A5]);
    chk("lat_rd_t0", mem_rd, 0);
    step(); input_address_ready = 1'b0;
    chk("lat_rd_t1", mem_rd, 1);
    chk("lat_addr_t1", mem_addr, 12'h2A5);
    step(); chk("lat_valid_t2", pixel_valid, 0);
    step(); chk("lat_valid_t3", pixel_valid, 1);
    chk("lat_data_t3", pixel_data, 8'h5C);
    step(); chk("lat_busy_idle", busy, 0);

    // backpressure: credit limits reads to OUT_DEPTH
    pixel_ready = 1'b0; r0 = rd_cnt; d0 = delivered;
    for (int i = 0; i < 6; i++) begin
      input_address = 12'(i); input_address_ready = 1'b1;
      sb.push_back(ram[i]);
      step();
    end
    input_address_ready = 1'b0;
    step(6);
    chk("bp_reads", rd_cnt - r0, OUT_DEPTH);
    chk("bp_overflow", overflow, 0);
    chk("bp_busy", busy, 1);
    pixel_ready = 1'b1;
    drain("bp_drain", 50);
    chk("bp_reads_all", rd_cnt - r0, 6);
    chk("bp_delivered", delivered - d0, 6);

    // en=0: request FIFO fills, fifth strobe dropped
    en = 1'b0; r0 = rd_cnt; d0 = delivered;
    for (int i = 0; i < 5; i++) begin
      input_address = 12'(12'h100 + i); input_address_ready = 1'b1;
      if (i < REQ_DEPTH) sb.push_back(ram[12'h100 + i]);
      step();
    end
    input_address_ready = 1'b0;
    step(3);
    chk("ovf_set", overflow, 1);
    chk("ovf_no_reads", rd_cnt - r0, 0);
    chk("ovf_busy", busy, 1);
    en = 1'b1;
    drain("ovf_drain", 50);
    step(5);
    chk("ovf_delivered", delivered - d0, REQ_DEPTH);
    chk("ovf_sticky", overflow, 1);

    // B path, back-to-back strobes
    for (int i = 0; i < 3; i++) begin
      push_b(ba[i]);
      step();
    end
    b_element_requested = 1'b0;
    drain("b_drain", 10);

    // reset with buffered pixels and a read in flight
    pixel_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      input_address = 12'(12'h200 + i); input_address_ready = 1'b1;
      sb.push_back(ram[12'h200 + i]);
      step();
    end
    input_address_ready = 1'b0;
    step();
    chk("prerst_valid", pixel_valid, 1);
    clear_n = 1'b0;
    #1;
    chk("midrst_valid", pixel_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overflow", overflow, 0);
    sb.delete();
    step(2);
    clear_n = 1'b1;
    pixel_ready = 1'b1;
    step(8);
    chk("postrst_valid", pixel_valid, 0);
    chk("postrst_busy", busy, 0);

    // random mix: en toggling, random backpressure, concurrent B strobes
    d0 = delivered; n_rand = 0;
    for (int i = 0; i < 600; i++) begin
      en = ~en;
      pixel_ready = ($urandom_range(0, 3) != 0);
      if (sb.size() < REQ_DEPTH && $urandom_range(0, 1) == 1) begin
        ra = ADDR_W'($urandom);
        input_address = ra; input_address_ready = 1'b1;
        sb.push_back(ram[ra]);
        n_rand++;
      end else input_address_ready = 1'b0;
      if ($urandom_range(0, 1) == 1) push_b(B_ADDR_W'($urandom));
      else b_element_requested = 1'b0;
      step();
    end
    input_address_ready = 1'b0; b_element_requested = 1'b0;
    en = 1'b1; pixel_ready = 1'b1;
    drain("rand_drain", 100);
    step(3);
    chk("rand_delivered", delivered - d0, n_rand);
    chk("rand_overflow", overflow, 0);
    chk("rand_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/first_stage_fetch_responder.md
Name: first_stage_fetch_responder

Overview:
- Memory-side responder for the first-stage quadrant address generator.
- Accepts input-pixel address strobes (input_address / input_address_ready) and B-vector element requests (b_element_address / b_element_requested).
- Reads the input RAM and the B RAM, each a synchronous 1-cycle-latency RAM.
- Returns pixel data in request order through a ready/valid stream with backpressure, and B elements as a valid pulse.

Parameters:
- ADDR_W, 12, input RAM address width
- B_ADDR_W, 9, B RAM address width
- DATA_W, 8, pixel data width
- B_DATA_W, 16, B element width
- REQ_DEPTH, 4, request FIFO depth (power of 2)
- OUT_DEPTH, 4, output FIFO depth (power of 2)

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- en  in  1  enables issuing pixel reads
- input_address  in  ADDR_W  pixel address from generator
- input_address_ready  in  1  1-cycle strobe, address valid
- b_element_address  in  B_ADDR_W  B element index
- b_element_requested  in  1  1-cycle strobe, B request
- mem_addr  out  ADDR_W  input RAM read address
- mem_rd  out  1  input RAM read enable
- mem_data  in  DATA_W  input RAM data, valid 1 cycle after mem_rd
- bmem_addr  out  B_ADDR_W  B RAM read address
- bmem_rd  out  1  B RAM read enable
- bmem_data  in  B_DATA_W  B RAM data, valid 1 cycle after bmem_rd
- pixel_data  out  DATA_W  head of output FIFO
- pixel_valid  out  1  output FIFO non-empty
- pixel_ready  in  1  consumer accepts pixel
- b_element_data  out  B_DATA_W  last fetched B element
- b_element_valid  out  1  1-cycle pulse, new B element
- busy  out  1  any pixel request queued, in flight or buffered
- overflow  out  1  sticky, a pixel request was dropped

Behaviour:
- Reset (clear_n=0, async): both FIFOs empty, inflight=0, all outputs 0.
- Request FIFO:
  - A cycle with input_address_ready=1 pushes input_address.
  - Push while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the request is dropped and overflow is set; overflow stays set until reset.
- Issue rule, evaluated in cycle t:
  - mem_rd=1 iff en=1, request FIFO non-empty, and out_count + inflight < OUT_DEPTH.
  - On issue, the FIFO head is popped and mem_addr=head.
  - mem_rd and mem_addr are registered; the pop decision is made from state at t, and mem_rd appears at t+1.
  - At most one read is issued per cycle.
- inflight:
  - Set in the cycle mem_rd=1; cleared the next cycle, when mem_data is written into the output FIFO.
  - Back-to-back issue every cycle is legal while credit is available.
- Credit guarantees that the output FIFO never overflows; no data is ever lost after issue.
- Output FIFO:
  - First-word-fall-through: pixel_valid = non-empty, pixel_data = head.
  - Pop when pixel_valid and pixel_ready.
  - Simultaneous write and pop when full is legal.
  - pixel_data holds stable while pixel_valid=1 and pixel_ready=0.
- Ordering: pixel_data order equals input_address_ready order, for accepted requests only.
- Latency, all FIFOs empty, en=1, pixel_ready=1:
  - strobe at cycle t → mem_rd at t+1 → pixel_valid at t+3.
- en=0:
  - Requests are still accepted; no new reads are issued.
  - An in-flight read completes; the output FIFO still drains.
- busy = request FIFO non-empty OR any mem_rd in the last 1 cycle OR output FIFO non-empty.
- B path:
  - Not gated by en; no FIFO.
  - A strobe at t registers bmem_addr and sets bmem_rd=1 at t+1.
  - At t+2, b_element_data is captured from bmem_data and b_element_valid pulses for 1 cycle.
  - b_element_data holds until the next capture.
  - Back-to-back strobes are fully pipelined, one per cycle.
- Reset mid-operation: all queued and in-flight requests are discarded immediately; no stale valid follows reset release.

Test Plan:
- Reset, en=1, pixel_ready=1, a single strobe with address 0x2A5, RAM[0x2A5]=0x5C → mem_rd=1 with mem_addr=0x2A5 one cycle later; pixel_valid=1 with data 0x5C three cycles after the strobe; busy then returns to 0.
- 6 consecutive strobes 0x000..0x005, pixel_ready=0 → only 4 reads issued; the 2 remaining requests wait in the request FIFO; overflow=0. Raising pixel_ready → 6 pixels delivered in order 0..5.
- en=0, 5 consecutive strobes → 4 queued, 5th dropped, overflow=1 and it stays 1. Raising en → exactly 4 pixels delivered.
- B strobes at cycles 10, 11, 12 with addresses 0x003, 0x1FF, 0x000 → b_element_valid at 12, 13, 14 with data B[0x003], B[0x1FF], B[0x000].
- Assert clear_n=0 with 3 pixels buffered and one read in flight → pixel_valid=0, busy=0, overflow=0 immediately. No pixel_valid after release until a new strobe.
- Pixel and B strobes in the same cycle, en toggling every cycle, random pixel_ready → a scoreboard sees every accepted pixel exactly once, in order, and every B element, with no overflow.
